// File: rtl/harris_df_pkg.sv
// Shared definitions for the Harris dataflow front end.
// DATA_W : pixel / memory word width
// ADDR_W : frame buffer address width (matches the core img_address0)
// DEPTH  : words per frame
// loader_state_t : loader FSM encoding
// sat_inc : 32-bit saturating increment, used by the optional cycle counter
package harris_df_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/harris_img_bram.sv
// Simple dual-port frame buffer, DEPTH x DATA_W, one write and one read port.
// Registered read; on a same-address write/read in one cycle the old word is returned.
// Only the read register is reset; the array contents survive reset.
// Ports:
//  clk, rst        clock, synchronous active-high reset (read register only)
//  we/waddr/wdata  write port
//  re/raddr        read enable / address
//  rdata           read data, valid the cycle after re; held while re=0
module harris_img_bram
  import harris_df_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking semantics give read-first behaviour on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/harris_img_loader.sv
// Upstream stage of the Harris HLS core. Collects one frame of pixels from a valid/ready
// stream into a frame buffer, starts the core with an ap_ctrl_hs handshake, serves the
// core's img read port from the buffer, and pulses frame_done when the core finishes.
// Ports:
//  clk, rst                 clock, synchronous active-high reset
//  s_valid/s_ready/s_data/s_last   pixel stream in (raster order)
//  ap_start/ap_ready/ap_done/ap_idle core control handshake
//  img_ce0/img_address0/img_q0     core read port (1-cycle read latency)
//  busy                     high while the core is being started or running
//  frame_done               1-cycle pulse per completed frame
//  err_len                  sticky frame length mismatch flag
//  run_cycles               only with HARRIS_LOADER_CYCLE_CNT_EN: start-to-done cycle count
module harris_img_loader
  import harris_df_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic              ap_idle,
  input  logic              img_ce0,
  input  logic [ADDR_W-1:0] img_address0,
  output logic [DATA_W-1:0] img_q0,
  output logic              busy,
  output logic              frame_done,
  output logic              err_len
`ifdef HARRIS_LOADER_CYCLE_CNT_EN
  ,
  output logic [31:0]       run_cycles
`endif
);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              err_len_q, err_len_d;
  logic              beat;
  logic              at_end;
  logic              done_hit;

  // Core idle is status only.
  logic unused_idle;
  assign unused_idle = ap_idle;

  // Outputs are gated by rst so that a reset drops them in the same cycle.
  assign s_ready    = (state_q == LOAD) && !rst;
  assign ap_start   = (state_q == START) && !rst;
  assign busy       = ((state_q == START) || (state_q == RUN)) && !rst;
  assign frame_done = (state_q == DONE) && !rst;
  assign err_len    = err_len_q;

  assign beat   = s_valid && s_ready;
  assign at_end = (wr_ptr_q == {ADDR_W{1'b1}});

  assign done_hit = ap_done && ((state_q == RUN) || ((state_q == START) && ap_ready));

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    err_len_d = err_len_q;
    unique case (state_q)
      LOAD: begin
        if (beat) begin
          // s_last must coincide exactly with the final buffer slot.
          if (s_last != at_end) begin
            err_len_d = 1'b1;
          end
          if (s_last || at_end) begin
            wr_ptr_d = '0;
            state_d  = START;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      START: begin
        if (ap_ready) begin
          state_d = ap_done ? DONE : RUN;
        end
      end
      RUN: begin
        if (ap_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      wr_ptr_q  <= '0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      err_len_q <= err_len_d;
    end
  end

  harris_img_bram u_bram (
    .clk   (clk),
    .rst   (rst),
    .we    (beat),
    .waddr (wr_ptr_q),
    .wdata (s_data),
    .re    (img_ce0),
    .raddr (img_address0),
    .rdata (img_q0)
  );

`ifdef HARRIS_LOADER_CYCLE_CNT_EN
  logic [31:0] cnt_q;
  logic [31:0] run_cycles_q;

  // cnt_q holds the number of START/RUN cycles already elapsed, so the ap_done cycle
  // itself is added when latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      run_cycles_q <= '0;
    end else begin
      if ((state_q == START) || (state_q == RUN)) begin
        cnt_q <= sat_inc(cnt_q);
      end else begin
        cnt_q <= '0;
      end
      if (done_hit) begin
        run_cycles_q <= sat_inc(cnt_q);
      end
    end
  end

  assign run_cycles = run_cycles_q;
`else
  logic unused_done_hit;
  assign unused_done_hit = done_hit;
`endif

endmodule

// File: tb/tb_harris_img_loader.sv
module tb_harris_img_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_done;
  logic        ap_idle;
  logic        img_ce0;
  logic [7:0]  img_address0;
  logic [31:0] img_q0;
  logic        busy;
  logic        frame_done;
  logic        err_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  harris_img_loader dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .ap_start     (ap_start),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .ap_idle      (ap_idle),
    .img_ce0      (img_ce0),
    .img_address0 (img_address0),
    .img_q0       (img_q0),
    .busy         (busy),
    .frame_done   (frame_done),
    .err_len      (err_len)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every cycle of this loop is a beat because s_ready stays high throughout LOAD.
  task automatic stream(input int n, input logic [31:0] base, input int last_idx);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = base + 32'(i);
      s_last  = (i == last_idx);
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    #1;
  endtask

  task automatic rd(input logic [7:0] a);
    img_ce0      = 1'b1;
    img_address0 = a;
    step();
    img_ce0 = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 0; s_data = 0; s_last = 0;
    ap_ready = 0; ap_done = 0; ap_idle = 1;
    img_ce0 = 0; img_address0 = 0;
    step();
    step();
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL reset_s_ready got %0b want 0", s_ready);
    end
    checks++;
    if ({ap_start, busy, frame_done, err_len} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {ap_start, busy, frame_done, err_len});
    end
    checks++;
    if (img_q0 !== 32'h0) begin
      errors++; $display("FAIL reset_img_q0 got %h want 0", img_q0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_s_ready got %0b want 1", s_ready);
    end
  endtask

  task automatic test_full_frame();
    stream(256, 32'h0, 255);
    checks++;
    if ({s_ready, ap_start, busy} !== 3'b011) begin
      errors++; $display("FAIL full_frame_start got %b want 011", {s_ready, ap_start, busy});
    end
    rd(8'h2A);
    checks++;
    if (img_q0 !== 32'h2A) begin
      errors++; $display("FAIL read_2a got %h want 0000002a", img_q0);
    end
    rd(8'hFF);
    checks++;
    if (img_q0 !== 32'hFF) begin
      errors++; $display("FAIL read_ff got %h want 000000ff", img_q0);
    end
    img_address0 = 8'h00;
    step();
    checks++;
    if (img_q0 !== 32'hFF) begin
      errors++; $display("FAIL read_hold got %h want 000000ff", img_q0);
    end
    checks++;
    if (err_len !== 1'b0) begin
      errors++; $display("FAIL full_frame_err got %0b want 0", err_len);
    end
  endtask

  task automatic test_handshake();
    int pulses = 0;
    step(); step(); step();
    checks++;
    if (ap_start !== 1'b1) begin
      errors++; $display("FAIL start_held got %0b want 1", ap_start);
    end
    ap_ready = 1'b1;
    step();
    ap_ready = 1'b0;
    #1;
    checks++;
    if ({ap_start, busy} !== 2'b01) begin
      errors++; $display("FAIL run_entry got %b want 01", {ap_start, busy});
    end
    for (int i = 0; i < 99; i++) begin
      if (i == 50) ap_ready = 1'b1;
      if (i == 51) ap_ready = 1'b0;
      if (frame_done === 1'b1) pulses++;
      step();
    end
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    #1;
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL early_frame_done got %0d pulses want 0", pulses);
    end
    checks++;
    if ({frame_done, busy, s_ready} !== 3'b100) begin
      errors++; $display("FAIL done_cycle got %b want 100", {frame_done, busy, s_ready});
    end
    step();
    checks++;
    if ({frame_done, s_ready, err_len} !== 3'b010) begin
      errors++; $display("FAIL back_to_load got %b want 010", {frame_done, s_ready, err_len});
    end
  endtask

  task automatic finish_same_cycle();
    ap_ready = 1'b1;
    ap_done  = 1'b1;
    step();
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    #1;
  endtask

  task automatic test_no_last();
    stream(256, 32'h2000, -1);
    checks++;
    if ({err_len, ap_start, s_ready} !== 3'b110) begin
      errors++; $display("FAIL no_last got %b want 110", {err_len, ap_start, s_ready});
    end
    rd(8'hFF);
    checks++;
    if (img_q0 !== 32'h20FF) begin
      errors++; $display("FAIL no_last_read got %h want 000020ff", img_q0);
    end
    finish_same_cycle();
    step();
  endtask

  task automatic test_early_last();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (err_len !== 1'b0) begin
      errors++; $display("FAIL err_cleared got %0b want 0", err_len);
    end
    stream(11, 32'h1000, 10);
    checks++;
    if ({err_len, ap_start} !== 2'b11) begin
      errors++; $display("FAIL early_last got %b want 11", {err_len, ap_start});
    end
    rd(8'd11);
    checks++;
    if (img_q0 !== 32'h200B) begin
      errors++; $display("FAIL stale_word got %h want 0000200b", img_q0);
    end
    rd(8'd10);
    checks++;
    if (img_q0 !== 32'h100A) begin
      errors++; $display("FAIL early_last_word got %h want 0000100a", img_q0);
    end
  endtask

  task automatic test_same_cycle_done();
    finish_same_cycle();
    checks++;
    if ({frame_done, busy, ap_start} !== 3'b100) begin
      errors++; $display("FAIL same_cycle_done got %b want 100", {frame_done, busy, ap_start});
    end
    step();
    checks++;
    if ({frame_done, s_ready} !== 2'b01) begin
      errors++; $display("FAIL same_cycle_reload got %b want 01", {frame_done, s_ready});
    end
  endtask

  task automatic test_reset_in_run();
    stream(3, 32'h4000, 2);
    ap_ready = 1'b1;
    step();
    ap_ready = 1'b0;
    #1;
    checks++;
    if ({busy, ap_start} !== 2'b10) begin
      errors++; $display("FAIL in_run got %b want 10", {busy, ap_start});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ap_start, busy, s_ready} !== 3'b000) begin
      errors++; $display("FAIL rst_asserted got %b want 000", {ap_start, busy, s_ready});
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({ap_start, busy, s_ready, err_len} !== 4'b0010) begin
      errors++; $display("FAIL after_rst got %b want 0010", {ap_start, busy, s_ready, err_len});
    end
    // First beat of the new frame writes addr 0 while reading it: old data expected.
    img_ce0      = 1'b1;
    img_address0 = 8'h00;
    s_valid = 1'b1;
    s_data  = 32'h3000;
    s_last  = 1'b0;
    step();
    img_ce0 = 1'b0;
    s_valid = 1'b0;
    #1;
    checks++;
    if (img_q0 !== 32'h4000) begin
      errors++; $display("FAIL read_first got %h want 00004000", img_q0);
    end
    stream(255, 32'h3001, 254);
    checks++;
    if ({ap_start, err_len} !== 2'b10) begin
      errors++; $display("FAIL reload_frame got %b want 10", {ap_start, err_len});
    end
    rd(8'h00);
    checks++;
    if (img_q0 !== 32'h3000) begin
      errors++; $display("FAIL reload_addr0 got %h want 00003000", img_q0);
    end
    rd(8'h80);
    checks++;
    if (img_q0 !== 32'h3080) begin
      errors++; $display("FAIL reload_addr80 got %h want 00003080", img_q0);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_handshake();
    test_no_last();
    test_early_last();
    test_same_cycle_done();
    test_reset_in_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
